// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one conditional branch from decode,
// waits for forwarded operands, evaluates the condition with a signed compare,
// and on a taken branch drives the PC redirect plus a multi-cycle flush.
// Fetch/decode is stalled for the whole sequence; saturating statistics are kept.
module branch_resolve_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,   // 1..15
   parameter int unsigned WAIT_MAX     = 8,   // 1..255
   parameter int unsigned CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             br_valid,
   output logic             br_ready,
   input  logic [2:0]       br_op,
   input  logic [31:0]      br_target,
   input  logic             ops_ready,
   input  logic [31:0]      rs_val,
   input  logic [31:0]      rt_val,
   output logic             stall,
   output logic             redirect,
   output logic [31:0]      pc_target,
   output logic             flush,
   output logic             resolved,
   output logic             taken,
   output logic             timeout,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RESOLVE = 2'd2,
      S_FLUSH   = 2'd3
   } state_t;

   localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
   localparam logic [7:0]       WAIT_LAST  = 8'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      target_q, target_d;
   logic [31:0]      rs_q, rs_d;
   logic [31:0]      rt_q, rt_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [3:0]       flush_cnt_q, flush_cnt_d;
   logic             stall_q, stall_d;
   logic             redirect_q, redirect_d;
   logic             flush_q, flush_d;
   logic             resolved_q, resolved_d;
   logic             taken_q, taken_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic             cond_s;

   // Branch condition on two's-complement operands; rt is ignored for the zero-compare ops.
   function automatic logic branch_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic res;
      case (op)
         3'd0:    res = (a == b);
         3'd1:    res = (a != b);
         3'd2:    res = ($signed(a) <  $signed(b));
         3'd3:    res = ($signed(a) >= $signed(b));
         3'd4:    res = ($signed(a) <= $signed(32'sd0));
         3'd5:    res = ($signed(a) >  $signed(32'sd0));
         3'd6:    res = ($signed(a) <  $signed(32'sd0));
         3'd7:    res = ($signed(a) >= $signed(32'sd0));
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Saturating increment for the statistics counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   assign cond_s    = branch_cond(op_q, rs_q, rt_q);
   assign br_ready  = (state_q == S_IDLE) && !Reset;
   assign stall     = stall_q;
   assign redirect  = redirect_q;
   assign pc_target = target_q;
   assign flush     = flush_q;
   assign resolved  = resolved_q;
   assign taken     = taken_q;
   assign timeout   = timeout_q;
   assign br_cnt    = br_cnt_q;
   assign taken_cnt = taken_cnt_q;

   // Next-state, capture and output-pulse logic for the resolution sequence.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      target_d    = target_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      wait_cnt_d  = wait_cnt_q;
      flush_cnt_d = flush_cnt_q;
      redirect_d  = 1'b0;
      resolved_d  = 1'b0;
      taken_d     = 1'b0;
      timeout_d   = 1'b0;
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (br_valid) begin
               op_d     = br_op;
               target_d = br_target;
               if (ops_ready) begin
                  rs_d    = rs_val;
                  rt_d    = rt_val;
                  state_d = S_RESOLVE;
               end else begin
                  wait_cnt_d = 8'd0;
                  state_d    = S_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (ops_ready) begin
               rs_d    = rs_val;
               rt_d    = rt_val;
               state_d = S_RESOLVE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               // Abandoned branch: no resolve pulse and no statistics update.
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_RESOLVE: begin
            resolved_d = 1'b1;
            br_cnt_d   = sat_inc(br_cnt_q);
            if (cond_s) begin
               redirect_d  = 1'b1;
               taken_d     = 1'b1;
               taken_cnt_d = sat_inc(taken_cnt_q);
               flush_cnt_d = FLUSH_LOAD;
               state_d     = S_FLUSH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FLUSH: begin
            flush_cnt_d = flush_cnt_q - 4'd1;
            if (flush_cnt_q == 4'd1) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Level outputs track the state being entered so they are registered.
      stall_d = (state_d != S_IDLE);
      flush_d = (state_d == S_FLUSH);
   end

   // State and output registers; synchronous reset abandons any in-flight branch.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         op_q        <= 3'd0;
         target_q    <= 32'd0;
         rs_q        <= 32'd0;
         rt_q        <= 32'd0;
         wait_cnt_q  <= 8'd0;
         flush_cnt_q <= 4'd0;
         stall_q     <= 1'b0;
         redirect_q  <= 1'b0;
         flush_q     <= 1'b0;
         resolved_q  <= 1'b0;
         taken_q     <= 1'b0;
         timeout_q   <= 1'b0;
         br_cnt_q    <= {CNT_W{1'b0}};
         taken_cnt_q <= {CNT_W{1'b0}};
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         target_q    <= target_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         wait_cnt_q  <= wait_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         stall_q     <= stall_d;
         redirect_q  <= redirect_d;
         flush_q     <= flush_d;
         resolved_q  <= resolved_d;
         taken_q     <= taken_d;
         timeout_q   <= timeout_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl. A second instance with 4-bit
// counters shares the stimulus so counter saturation can be observed quickly.
module tb_branch_resolve_ctrl;

   localparam int F  = 2;
   localparam int WM = 8;

   logic        Clk = 1'b0;
   logic        Reset, br_valid, ops_ready;
   logic [2:0]  br_op;
   logic [31:0] br_target, rs_val, rt_val;

   logic        br_ready, stall, redirect, flush, resolved, taken, timeout;
   logic [31:0] pc_target;
   logic [15:0] br_cnt, taken_cnt;

   logic        s_br_ready, s_stall, s_redirect, s_flush, s_resolved, s_taken, s_timeout;
   logic [31:0] s_pc_target;
   logic [3:0]  s_br_cnt, s_taken_cnt;

   int checks = 0;
   int errors = 0;
   int mdl_br = 0;
   int mdl_tk = 0;

   always #5 Clk = ~Clk;

   branch_resolve_ctrl #(.FLUSH_CYCLES(F), .WAIT_MAX(WM), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .br_valid(br_valid), .br_ready(br_ready),
      .br_op(br_op), .br_target(br_target), .ops_ready(ops_ready),
      .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .redirect(redirect),
      .pc_target(pc_target), .flush(flush), .resolved(resolved), .taken(taken),
      .timeout(timeout), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   branch_resolve_ctrl #(.FLUSH_CYCLES(F), .WAIT_MAX(WM), .CNT_W(4)) dut_small (
      .Clk(Clk), .Reset(Reset), .br_valid(br_valid), .br_ready(s_br_ready),
      .br_op(br_op), .br_target(br_target), .ops_ready(ops_ready),
      .rs_val(rs_val), .rt_val(rt_val), .stall(s_stall), .redirect(s_redirect),
      .pc_target(s_pc_target), .flush(s_flush), .resolved(s_resolved), .taken(s_taken),
      .timeout(s_timeout), .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
   );

   // Reference branch rule on signed integers.
   function automatic bit ref_taken(input int op, input int a, input int b);
      case (op)
         0: return a == b;
         1: return a != b;
         2: return a < b;
         3: return a >= b;
         4: return a <= 0;
         5: return a > 0;
         6: return a < 0;
         7: return a >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 3));
         default: return 32'($urandom);
      endcase
   endfunction

   // One branch transaction: accept at k=0, operands become ready at k=d,
   // optional reset asserted during cycle rst_at. Every cycle is compared
   // against the timeline derived from the documented latencies.
   task automatic run_branch(input int op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] tgt, input int d, input int rst_at);
      bit to, tk;
      int r, idle_k;
      logic [6:0] got_v, exp_v;
      to = (d > WM);
      tk = !to && ref_taken(op, int'(a), int'(b));
      r  = 1 + d;
      idle_k = to ? (1 + WM) : (tk ? (r + F + 1) : (r + 1));
      for (int k = 0; k <= idle_k; k++) begin
         @(negedge Clk);
         if (!to && k == r + 1) begin
            mdl_br++;
            if (tk) mdl_tk++;
         end
         exp_v = {(k >= 1 && k < idle_k),                  // stall
                  (tk && k == r + 1),                      // redirect
                  (tk && k >= r + 1 && k <= r + F),        // flush
                  (!to && k == r + 1),                     // resolved
                  (tk && k == r + 1),                      // taken
                  (to && k == idle_k),                     // timeout
                  (k == 0 || k == idle_k)};                // br_ready
         got_v = {stall, redirect, flush, resolved, taken, timeout, br_ready};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL outputs op=%0d d=%0d k=%0d {stall,redir,flush,res,taken,tmo,rdy} got %b exp %b",
                     op, d, k, got_v, exp_v);
         end
         checks++;
         if (br_cnt !== 16'(sat(mdl_br, 65535)) || taken_cnt !== 16'(sat(mdl_tk, 65535))) begin
            errors++;
            $display("FAIL counters k=%0d got br=%0d tk=%0d exp br=%0d tk=%0d",
                     k, br_cnt, taken_cnt, sat(mdl_br, 65535), sat(mdl_tk, 65535));
         end
         checks++;
         if (s_br_cnt !== 4'(sat(mdl_br, 15)) || s_taken_cnt !== 4'(sat(mdl_tk, 15))) begin
            errors++;
            $display("FAIL sat_counters k=%0d got br=%0d tk=%0d exp br=%0d tk=%0d",
                     k, s_br_cnt, s_taken_cnt, sat(mdl_br, 15), sat(mdl_tk, 15));
         end
         if (tk && k == r + 1) begin
            checks++;
            if (pc_target !== tgt) begin
               errors++;
               $display("FAIL pc_target got %h exp %h", pc_target, tgt);
            end
         end
         if (k == rst_at) begin
            Reset = 1'b1; br_valid = 1'b0; ops_ready = 1'b0;
            @(negedge Clk);
            mdl_br = 0; mdl_tk = 0;
            got_v = {stall, redirect, flush, resolved, taken, timeout, br_ready};
            checks++;
            if (got_v !== 7'b0 || br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin
               errors++;
               $display("FAIL reset_mid got outs %b br=%0d tk=%0d exp all 0", got_v, br_cnt, taken_cnt);
            end
            Reset = 1'b0;
            return;
         end
         // Inputs for cycle k; garbage outside the capture points must be ignored.
         br_valid  = (k == 0) ? 1'b1 : ((k < idle_k) ? 1'($urandom_range(0, 1)) : 1'b0);
         br_op     = (k == 0) ? 3'(op) : 3'($urandom);
         br_target = (k == 0) ? tgt : 32'($urandom);
         ops_ready = (k >= d && k < idle_k) ? 1'b1 : 1'b0;
         rs_val    = (k == d) ? a : 32'($urandom);
         rt_val    = (k == d) ? b : 32'($urandom);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; br_valid = 1'b1; ops_ready = 1'b1; br_op = 3'd0;
      br_target = 32'h1234; rs_val = 32'd0; rt_val = 32'd0;
      repeat (3) @(negedge Clk);
      checks++;
      if ({br_ready, stall, redirect, flush, resolved, taken, timeout} !== 7'b0 ||
          br_cnt !== 16'd0 || taken_cnt !== 16'd0 || pc_target !== 32'd0) begin
         errors++;
         $display("FAIL reset_state got rdy=%b stall=%b br=%0d pc=%h exp all 0",
                  br_ready, stall, br_cnt, pc_target);
      end
      Reset = 1'b0; br_valid = 1'b0; ops_ready = 1'b0;
   endtask

   task automatic test_taken_beq();
      run_branch(0, 32'd5, 32'd5, 32'hCAFE_0100, 0, -1);
      run_branch(1, 32'd7, 32'd7, 32'h0000_0040, 0, -1);
   endtask

   task automatic test_signed_edges();
      run_branch(2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_2000, 0, -1);
      run_branch(5, 32'hFFFF_FFFF, 32'd0, 32'h0000_3000, 0, -1);
      run_branch(6, 32'hFFFF_FFFF, 32'd0, 32'h0000_3100, 0, -1);
      run_branch(4, 32'd0, 32'hFFFF_FFFF, 32'h0000_3200, 0, -1);
      run_branch(3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_3300, 0, -1);
   endtask

   task automatic test_wait_bne();
      run_branch(1, 32'd1, 32'd2, 32'h0000_4000, 3, -1);
      run_branch(1, 32'd9, 32'd9, 32'h0000_4100, 3, -1);
      run_branch(7, 32'd0, 32'd0, 32'h0000_4200, WM, -1);
   endtask

   task automatic test_timeout();
      run_branch(0, 32'd1, 32'd1, 32'h0000_5000, WM + 1, -1);
      run_branch(0, 32'd1, 32'd1, 32'h0000_5100, 0, -1);
   endtask

   task automatic test_reset_mid_flush();
      run_branch(0, 32'd5, 32'd5, 32'h0000_6000, 0, 2);
      run_branch(2, 32'd1, 32'd2, 32'h0000_6100, 1, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_branch(int'($urandom_range(0, 7)), pick_val(), pick_val(),
                    32'($urandom), int'($urandom_range(0, WM + 2)), -1);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         run_branch(0, 32'd3, 32'd3, 32'h0000_7000 + 32'(i), 0, -1);
      end
      checks++;
      if (s_br_cnt !== 4'd15 || s_taken_cnt !== 4'd15) begin
         errors++;
         $display("FAIL saturation got br=%0d tk=%0d exp 15 15", s_br_cnt, s_taken_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_taken_beq();
      test_signed_edges();
      test_wait_bne();
      test_timeout();
      test_reset_mid_flush();
      test_random();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
